// File: rtl/shl_pkg.sv
// Shared types and constants for the pipelined left shifter/rotator.
package shl_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_TAG_W = 4;
  localparam int DEF_SHW   = $clog2(DEF_WIDTH);

  // Shift flavour carried with each operand.
  typedef enum logic {
    SHL_LOGIC  = 1'b0,
    SHL_ROTATE = 1'b1
  } shift_op_e;

  // Contents of one pipeline stage at the default width. Other widths
  // carry the same fields as separate signals inside the module.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_SHW-1:0]   shamt;
    shift_op_e            op;
    logic                 carry;
    logic [DEF_TAG_W-1:0] tag;
  } stage_t;

  // Stage k (0-based) keeps only the shift-amount bits still to be
  // consumed downstream, SHW-1-k of them. These triangular slices are
  // packed back to back in one vector. This returns the bit offset of
  // stage k's slice.
  function automatic int rem_offset(input int shw, input int k);
    return k * (shw - 1) - (k * (k - 1)) / 2;
  endfunction

endpackage

// File: rtl/shl_pipe_stage.sv
// One registered stage of the left shifter. It conditionally shifts or
// rotates by a fixed power-of-two amount and tracks the bit pushed past
// the MSB.
module shl_pipe_stage
  import shl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W,
  parameter int SHAMT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  shift_op_e        up_op,
  input  logic             up_carry,
  input  logic [TAG_W-1:0] up_tag,
  output logic             valid_reg,
  output logic [WIDTH-1:0] data_reg,
  output logic             carry_reg,
  output logic [TAG_W-1:0] tag_reg
);

  logic [WIDTH-1:0] data_next;
  logic             carry_next;

  // Shift or rotate by SHAMT when this stage's amount bit is set.
  // Otherwise pass data and carry through untouched.
  always_comb begin
    data_next  = up_data;
    carry_next = up_carry;
    if (shift_en) begin
      // The carry is the last bit to cross the MSB, taken from the
      // stage input. It is the same for both ops.
      carry_next = up_data[WIDTH-SHAMT];
      if (up_op == SHL_ROTATE) begin
        data_next = {up_data[WIDTH-1-SHAMT:0], up_data[WIDTH-1:WIDTH-SHAMT]};
      end else begin
        data_next = {up_data[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
      end
    end
  end

  // Stage register. It loads whenever downstream can make room. A
  // bubble upstream loads a cleared valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      carry_reg <= 1'b0;
      tag_reg   <= '0;
    end else if (load) begin
      valid_reg <= up_valid;
      data_reg  <= data_next;
      carry_reg <= carry_next;
      tag_reg   <= up_tag;
    end
  end

endmodule

// File: rtl/shl_pipe.sv
// Pipelined, back-pressured left shifter/rotator. It uses one registered
// stage per shift-amount bit, from the MSB first. Results return in
// issue order with carry-out and tag.
module shl_pipe
  import shl_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int TAG_W = DEF_TAG_W,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  shift_op_e        in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag
);

  // Total width of the leftover shift-amount slices and of the op
  // bits. The last stage needs neither, so both sets are one stage
  // short.
  localparam int REM_TOT = SHW * (SHW - 1) / 2;
  localparam int REM_W   = (REM_TOT > 0) ? REM_TOT : 1;
  localparam int OP_W    = (SHW > 1) ? SHW - 1 : 1;

  // Outputs of each datapath stage, indexed 0..SHW-1 from the input side.
  logic [SHW-1:0]   valid_q;
  logic [WIDTH-1:0] data_q [SHW];
  logic [SHW-1:0]   carry_q;
  logic [TAG_W-1:0] tag_q  [SHW];

  // Control still travelling with each operand (stages 0..SHW-2 only).
  logic [REM_W-1:0] rem_flat;
  logic [OP_W-1:0]  op_flat;

  // accept_vec[k] means stage k may load this cycle.
  // accept_vec[SHW] is the consumer.
  logic [SHW:0] accept_vec;

  // Stall chain: a stage can load if it is empty or its occupant moves
  // on. The chain is evaluated from the output back to the input in one
  // pass.
  always_comb begin
    accept_vec      = '0;
    accept_vec[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      accept_vec[k] = !valid_q[k] | accept_vec[k + 1];
    end
  end

  assign in_ready  = accept_vec[0];
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_carry = carry_q[SHW-1];
  assign out_tag   = tag_q[SHW-1];

  for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
    // Shift-amount bit consumed here. The first stage takes the MSB
    // and shifts by WIDTH/2.
    localparam int BIT = SHW - 1 - gi;

    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             up_carry;
    logic [TAG_W-1:0] up_tag;
    shift_op_e        up_op;
    logic [BIT:0]     up_shamt;

    if (gi == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
      assign up_carry = 1'b0;
      assign up_tag   = in_tag;
      assign up_op    = in_op;
      assign up_shamt = in_shamt;
    end else begin : g_body
      localparam int UP_OFF = rem_offset(SHW, gi - 1);
      assign up_valid = valid_q[gi-1];
      assign up_data  = data_q[gi-1];
      assign up_carry = carry_q[gi-1];
      assign up_tag   = tag_q[gi-1];
      assign up_op    = shift_op_e'(op_flat[gi-1]);
      assign up_shamt = rem_flat[UP_OFF +: BIT+1];
    end

    shl_pipe_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .SHAMT (1 << BIT)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept_vec[gi]),
      .shift_en  (up_shamt[BIT]),
      .up_valid  (up_valid),
      .up_data   (up_data),
      .up_op     (up_op),
      .up_carry  (up_carry),
      .up_tag    (up_tag),
      .valid_reg (valid_q[gi]),
      .data_reg  (data_q[gi]),
      .carry_reg (carry_q[gi]),
      .tag_reg   (tag_q[gi])
    );

    if (gi < SHW - 1) begin : g_ctl
      localparam int OFF = rem_offset(SHW, gi);

      logic [BIT-1:0] rem_reg;
      shift_op_e      op_reg;

      // Op and the unconsumed low amount bits move in lockstep with
      // the datapath stage, under the same load enable.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_reg <= '0;
          op_reg  <= SHL_LOGIC;
        end else if (accept_vec[gi]) begin
          rem_reg <= up_shamt[BIT-1:0];
          op_reg  <= up_op;
        end
      end

      assign rem_flat[OFF +: BIT] = rem_reg;
      assign op_flat[gi]          = op_reg;
    end
  end

endmodule

// File: tb/tb_shl_pipe.sv
// Self-checking bench for shl_pipe. It uses directed vectors, latency,
// stall, reset and random traffic, all scored against an arithmetic
// reference queue.
module tb_shl_pipe;
  import shl_pkg::*;

  localparam int W   = 64;
  localparam int TW  = 4;
  localparam int SHW = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic [SHW-1:0]  in_shamt = '0;
  shift_op_e       in_op = SHL_LOGIC;
  logic [TW-1:0]   in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_data;
  logic            out_carry;
  logic [TW-1:0]   out_tag;

  shl_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic          carry;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int calls = 0;
  int ret_cnt = 0;
  int acc_call = -1;
  int ret_call = -1;
  int ov_seen = 0;
  logic acc = 1'b0;
  logic ret = 1'b0;
  logic hold_active = 1'b0;
  logic [W-1:0]  hold_data = '0;
  logic [TW-1:0] hold_tag = '0;
  logic [W-1:0]  last_data = '0;
  logic          last_carry = 1'b0;
  logic [TW-1:0] last_tag = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a left shift by s with zero fill, or with the top s bits
  // wrapped in. The carry is the last bit pushed out, which is bit W-s.
  function automatic exp_t model(input logic [W-1:0] d, input int s,
                                 input shift_op_e op, input logic [TW-1:0] t);
    exp_t e;
    e.tag = t;
    if (s == 0) begin
      e.data  = d;
      e.carry = 1'b0;
    end else begin
      e.data = d << s;
      if (op == SHL_ROTATE) e.data = e.data | (d >> (W - s));
      e.carry = d[W-s];
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [SHW-1:0] s,
                       input shift_op_e op, input logic [TW-1:0] t);
    in_valid = v;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    in_tag   = t;
  endtask

  // One clock. Handshakes are sampled at the falling edge, the result is
  // scored, a newly accepted operand is modelled, and the task returns
  // just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    ret = out_valid && out_ready;
    if (out_valid) ov_seen++;
    if (hold_active) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_data", out_data, hold_data);
      chk("stall_tag", 64'(out_tag), 64'(hold_tag));
    end
    hold_active = out_valid && !out_ready;
    hold_data   = out_data;
    hold_tag    = out_tag;
    if (ret) begin
      ret_cnt++;
      ret_call   = calls;
      last_data  = out_data;
      last_carry = out_carry;
      last_tag   = out_tag;
      if (sb.size() == 0) begin
        chk("out_without_input", 64'(out_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        $display("RESULT tag=%0h data=%016h carry=%0b exp_data=%016h exp_carry=%0b",
                 out_tag, out_data, out_carry, e.data, e.carry);
        chk("res_data", out_data, e.data);
        chk("res_carry", 64'(out_carry), 64'(e.carry));
        chk("res_tag", 64'(out_tag), 64'(e.tag));
      end
    end
    if (acc) begin
      sb.push_back(model(in_data, int'(in_shamt), in_op, in_tag));
      acc_call = calls;
    end
    @(posedge clk);
    #1;
    calls++;
  endtask

  // Issue one operand into an empty pipe and compare its result with
  // hand-derived constants.
  task automatic send_one(input logic [W-1:0] d, input logic [SHW-1:0] s, input shift_op_e op,
                          input logic [TW-1:0] t, input logic [W-1:0] ed, input logic ec);
    int n0;
    n0 = ret_cnt;
    out_ready = 1'b1;
    drive(1'b1, d, s, op, t);
    cycle();
    chk("dir_accept", 64'(acc), 64'(1));
    in_valid = 1'b0;
    for (int i = 0; i < 20 && ret_cnt == n0; i++) cycle();
    chk("dir_returned", 64'(ret_cnt - n0), 64'(1));
    chk("dir_data", last_data, ed);
    chk("dir_carry", 64'(last_carry), 64'(ec));
    chk("dir_tag", 64'(last_tag), 64'(t));
  endtask

  initial begin
    int nt;
    int base;
    int ov0;
    int a_call;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_out_carry", 64'(out_carry), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // An empty pipe is ready regardless of the consumer
    out_ready = 1'b0;
    #1;
    chk("empty_in_ready", 64'(in_ready), 64'(1));

    // Directed vectors
    send_one(64'h8000_0000_0000_0001, 6'd1, SHL_LOGIC, 4'h3, 64'h0000_0000_0000_0002, 1'b1);
    send_one(64'h8000_0000_0000_0001, 6'd1, SHL_ROTATE, 4'h5, 64'h0000_0000_0000_0003, 1'b1);
    send_one(64'h0000_0000_0000_0001, 6'd63, SHL_LOGIC, 4'h7, 64'h8000_0000_0000_0000, 1'b0);
    send_one(64'hDEAD_BEEF_0123_4567, 6'd0, SHL_LOGIC, 4'h9, 64'hDEAD_BEEF_0123_4567, 1'b0);
    send_one(64'hDEAD_BEEF_0123_4567, 6'd0, SHL_ROTATE, 4'hA, 64'hDEAD_BEEF_0123_4567, 1'b0);
    send_one(64'h0F00_0000_0000_00F0, 6'd8, SHL_ROTATE, 4'h2, 64'h0000_0000_0000_F00F, 1'b1);

    // Latency: a lone operand shows up exactly SHW edges later, for one cycle
    out_ready = 1'b1;
    ov0 = ov_seen;
    drive(1'b1, {$urandom, $urandom}, 6'd5, SHL_LOGIC, 4'hB);
    cycle();
    chk("lat_accept", 64'(acc), 64'(1));
    a_call = acc_call;
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    chk("lat_edges", 64'(ret_call - a_call), 64'(SHW));
    chk("lat_valid_cycles", 64'(ov_seen - ov0), 64'(1));

    // Stall: only SHW operands fit, then in-order drain with live input
    out_ready = 1'b0;
    nt = 0;
    base = ret_cnt;
    for (int i = 0; i < 12; i++) begin
      if (nt < 10) drive(1'b1, {$urandom, $urandom}, 6'($urandom_range(0, 63)),
                         shift_op_e'($urandom_range(0, 1)), 4'(nt));
      else in_valid = 1'b0;
      cycle();
      if (acc) nt++;
    end
    chk("stall_accepted", 64'(nt), 64'(SHW));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 40 && ret_cnt - base < 10; i++) begin
      if (nt < 10) drive(1'b1, {$urandom, $urandom}, 6'($urandom_range(0, 63)),
                         shift_op_e'($urandom_range(0, 1)), 4'(nt));
      else in_valid = 1'b0;
      cycle();
      if (acc) nt++;
    end
    chk("drain_count", 64'(ret_cnt - base), 64'(10));
    chk("drain_sb_empty", 64'(sb.size()), 64'(0));

    // Throughput: simultaneous accept and drain every cycle
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, {$urandom, $urandom}, 6'($urandom_range(0, 63)),
            shift_op_e'($urandom_range(0, 1)), 4'(i));
      cycle();
      if (acc) nt++;
    end
    in_valid = 1'b0;
    chk("thru_accepts", 64'(nt), 64'(20));
    for (int i = 0; i < 12 && sb.size() > 0; i++) cycle();
    chk("thru_sb_empty", 64'(sb.size()), 64'(0));

    // Asynchronous reset with three operands in flight, the oldest at the output
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, {$urandom, $urandom} | 64'h1, 6'($urandom_range(1, 63)),
            shift_op_e'($urandom_range(0, 1)), 4'(12 + i));
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("pre_rst_out_valid", 64'(out_valid), 64'(1));
    chk("pre_rst_inflight", 64'(sb.size()), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_data", out_data, 64'(0));
    chk("mid_rst_out_carry", 64'(out_carry), 64'(0));
    chk("mid_rst_out_tag", 64'(out_tag), 64'(0));
    sb.delete();
    hold_active = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    ov0 = ov_seen;
    for (int i = 0; i < 12; i++) cycle();
    chk("post_rst_no_out", 64'(ov_seen - ov0), 64'(0));

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        drive(1'b1, {$urandom, $urandom}, 6'($urandom_range(0, 63)),
              shift_op_e'($urandom_range(0, 1)), 4'($urandom));
      else
        in_valid = 1'b0;
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
    chk("rand_sb_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
